// File: rtl/dac_setpoint_writer.sv
// Serial writer for a 24-bit SPI-style DAC frame {6'b0, pd, data}, MSB first, DIN updated while SCLK is high.
// Latency: launch decided in cycle N, SYNC_n low in N+1, done pulse 2+SYNC_SETUP+48*CLK_DIV+SYNC_GAP-1 cycles after N.
// Backpressure: none on wr_req; requests during a frame park in a one-deep last-write-wins slot, a force_zero edge overrides it.
module dac_setpoint_writer #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned SYNC_SETUP = 2,
  parameter int unsigned SYNC_GAP   = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wr_req,
  input  logic [15:0] wr_data,
  input  logic [1:0]  wr_pd,
  input  logic        force_zero,
  output logic        wr_ack,
  output logic        busy,
  output logic        done,
  output logic [15:0] last_value,
  output logic        dac_sync_n,
  output logic        dac_sclk,
  output logic        dac_din
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOW,
    S_HIGH,
    S_HOLD,
    S_GAP
  } state_t;

  // Phase counters count down from (length-1); 8 bits covers the 1..255 parameter range.
  localparam logic [7:0] SETUP_LD = 8'(SYNC_SETUP - 1);
  localparam logic [7:0] DIV_LD   = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LD   = 8'(SYNC_GAP - 1);
  localparam logic [4:0] LAST_BIT = 5'd23;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic [23:0] sh_q, sh_d;
  logic [15:0] cur_q, cur_d;

  logic        fz_q, fz_d;
  logic        zero_pend_q, zero_pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic [15:0] pend_data_q, pend_data_d;
  logic [1:0]  pend_pd_q, pend_pd_d;

  logic        wr_ack_q, wr_ack_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] last_q, last_d;
  logic        sync_n_q, sync_n_d;
  logic        sclk_q, sclk_d;
  logic        din_q, din_d;

  logic        fz_edge;
  logic        zero_req;
  logic        launch;
  logic        launch_live;
  logic [15:0] launch_data;
  logic [1:0]  launch_pd;
  logic [23:0] launch_frame;

  // Source arbitration while idle: zero request, then parked request, then live request.
  always_comb begin
    fz_edge     = force_zero & ~fz_q;
    zero_req    = zero_pend_q | fz_edge;
    launch      = 1'b0;
    launch_live = 1'b0;
    launch_data = 16'h0000;
    launch_pd   = 2'b00;
    if (state_q == S_IDLE) begin
      if (zero_req) begin
        launch = 1'b1;
      end else if (pend_vld_q) begin
        launch      = 1'b1;
        launch_data = pend_data_q;
        launch_pd   = pend_pd_q;
      end else if (wr_req) begin
        launch      = 1'b1;
        launch_live = 1'b1;
        launch_data = wr_data;
        launch_pd   = wr_pd;
      end
    end
    launch_frame = {6'b000000, launch_pd, launch_data};
  end

  // Frame sequencer, pending-slot bookkeeping and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    cur_d       = cur_q;
    fz_d        = force_zero;
    zero_pend_d = zero_pend_q;
    pend_vld_d  = pend_vld_q;
    pend_data_d = pend_data_q;
    pend_pd_d   = pend_pd_q;
    wr_ack_d    = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    last_d      = last_q;
    sync_n_d    = sync_n_q;
    sclk_d      = sclk_q;
    din_d       = din_q;

    // A safety edge supersedes whatever data was parked.
    if (fz_edge) begin
      zero_pend_d = 1'b1;
      pend_vld_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d  = S_SETUP;
          cnt_d    = SETUP_LD;
          bit_d    = 5'd0;
          sh_d     = launch_frame;
          cur_d    = launch_data;
          busy_d   = 1'b1;
          sync_n_d = 1'b0;
          sclk_d   = 1'b1;
          din_d    = launch_frame[23];
          wr_ack_d = launch_live;
          if (zero_req) begin
            zero_pend_d = 1'b0;
            pend_vld_d  = 1'b0;
          end else if (!launch_live) begin
            pend_vld_d = 1'b0;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = S_LOW;
          cnt_d   = DIV_LD;
          sclk_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_LOW: begin
        if (cnt_q == 8'd0) begin
          cnt_d  = DIV_LD;
          sclk_d = 1'b1;
          if (bit_q == LAST_BIT) begin
            state_d = S_HOLD;
            din_d   = 1'b0;
          end else begin
            state_d = S_HIGH;
            bit_d   = bit_q + 5'd1;
            sh_d    = {sh_q[22:0], 1'b0};
            din_d   = sh_q[22];
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_HIGH: begin
        if (cnt_q == 8'd0) begin
          state_d = S_LOW;
          cnt_d   = DIV_LD;
          sclk_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d  = S_GAP;
          cnt_d    = GAP_LD;
          sync_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          last_d  = cur_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        busy_d   = 1'b0;
        sync_n_d = 1'b1;
        sclk_d   = 1'b1;
        din_d    = 1'b0;
      end
    endcase

    // Any request not launched directly is parked and acked; a same-cycle safety edge drops it unacked.
    if (wr_req && !fz_edge && !launch_live) begin
      pend_vld_d  = 1'b1;
      pend_data_d = wr_data;
      pend_pd_d   = wr_pd;
      wr_ack_d    = 1'b1;
    end
  end

  // State and output registers; reset aborts any frame and empties both pending slots.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      bit_q       <= 5'd0;
      sh_q        <= 24'h000000;
      cur_q       <= 16'h0000;
      fz_q        <= 1'b0;
      zero_pend_q <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_data_q <= 16'h0000;
      pend_pd_q   <= 2'b00;
      wr_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      last_q      <= 16'h0000;
      sync_n_q    <= 1'b1;
      sclk_q      <= 1'b1;
      din_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      cur_q       <= cur_d;
      fz_q        <= fz_d;
      zero_pend_q <= zero_pend_d;
      pend_vld_q  <= pend_vld_d;
      pend_data_q <= pend_data_d;
      pend_pd_q   <= pend_pd_d;
      wr_ack_q    <= wr_ack_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      last_q      <= last_d;
      sync_n_q    <= sync_n_d;
      sclk_q      <= sclk_d;
      din_q       <= din_d;
    end
  end

  assign wr_ack     = wr_ack_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign last_value = last_q;
  assign dac_sync_n = sync_n_q;
  assign dac_sclk   = sclk_q;
  assign dac_din    = din_q;

endmodule

// File: tb/tb_dac_setpoint_writer.sv
// Directed bench for dac_setpoint_writer: default-timing instance plus a minimum-parameter instance.
// Cycle 0 is the cycle in which a request is driven; DUT outputs are sampled on the falling clock edge.
// A watchdog bounds the run.
module tb_dac_setpoint_writer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;

  logic        a_wr_req = 1'b0;
  logic [15:0] a_wr_data = 16'h0000;
  logic [1:0]  a_wr_pd = 2'b00;
  logic        a_force_zero = 1'b0;
  logic        a_wr_ack, a_busy, a_done, a_sync_n, a_sclk, a_din;
  logic [15:0] a_last_value;

  logic        b_wr_req = 1'b0;
  logic [15:0] b_wr_data = 16'h0000;
  logic [1:0]  b_wr_pd = 2'b00;
  logic        b_force_zero = 1'b0;
  logic        b_wr_ack, b_busy, b_done, b_sync_n, b_sclk, b_din;
  logic [15:0] b_last_value;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  dac_setpoint_writer dut_a (
    .clk(clk), .rstn(rstn), .wr_req(a_wr_req), .wr_data(a_wr_data), .wr_pd(a_wr_pd),
    .force_zero(a_force_zero), .wr_ack(a_wr_ack), .busy(a_busy), .done(a_done),
    .last_value(a_last_value), .dac_sync_n(a_sync_n), .dac_sclk(a_sclk), .dac_din(a_din)
  );

  dac_setpoint_writer #(.CLK_DIV(1), .SYNC_SETUP(1), .SYNC_GAP(1)) dut_b (
    .clk(clk), .rstn(rstn), .wr_req(b_wr_req), .wr_data(b_wr_data), .wr_pd(b_wr_pd),
    .force_zero(b_force_zero), .wr_ack(b_wr_ack), .busy(b_busy), .done(b_done),
    .last_value(b_last_value), .dac_sync_n(b_sync_n), .dac_sclk(b_sclk), .dac_din(b_din)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Observer for instance A: reconstructs frames from the DAC pins and records event cycles.
  logic        sclk_p = 1'b1, sync_p = 1'b1, din_p = 1'b0;
  logic [23:0] rx = 24'h0, last_frame = 24'h0;
  int nfall = 0, last_frame_bits = 0;
  int first_fall_cyc = 0, last_fall_cyc = 0, sync_fall_cyc = 0, sync_rise_cyc = 0;
  int done_cyc = 0, n_done = 0, n_ack = 0, n_frames = 0, n_busy = 0, din_viol = 0;
  logic [15:0] lv_at_done = 16'h0;

  always @(negedge clk) begin
    if (!rstn) begin
      nfall  = 0;
      rx     = 24'h0;
      sclk_p = 1'b1;
      sync_p = 1'b1;
      din_p  = 1'b0;
    end else begin
      if (sync_p && !a_sync_n) begin
        sync_fall_cyc = cyc;
        nfall = 0;
        rx = 24'h0;
      end
      if (!a_sync_n && !sync_p && !a_sclk && (a_din !== din_p)) din_viol++;
      if (sclk_p && !a_sclk && !a_sync_n) begin
        if (nfall == 0) first_fall_cyc = cyc;
        last_fall_cyc = cyc;
        rx = {rx[22:0], a_din};
        nfall++;
      end
      if (!sync_p && a_sync_n) begin
        sync_rise_cyc = cyc;
        last_frame = rx;
        last_frame_bits = nfall;
        n_frames++;
      end
      if (a_done) begin
        done_cyc = cyc;
        lv_at_done = a_last_value;
        n_done++;
      end
      if (a_wr_ack) n_ack++;
      if (a_busy) n_busy++;
      sclk_p = a_sclk;
      sync_p = a_sync_n;
      din_p  = a_din;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  int t0, frames0, acks0, done0, busy0;
  logic [23:0] rxb;
  int nb, ffb, dkb;
  logic spb;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_wr_ack", a_wr_ack, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_last_value", a_last_value, 0);
    chk("rst_sync_n", a_sync_n, 1);
    chk("rst_sclk", a_sclk, 1);
    chk("rst_din", a_din, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Single write 0xA5C3 with default timing
    t0 = cyc; busy0 = n_busy;
    a_wr_req = 1'b1; a_wr_data = 16'hA5C3; a_wr_pd = 2'b00;
    @(negedge clk);
    a_wr_req = 1'b0;
    chk("t1_ack_c1", a_wr_ack, 1);
    chk("t1_busy_c1", a_busy, 1);
    chk("t1_sync_c1", a_sync_n, 0);
    chk("t1_din_c1", a_din, 0);
    wait_until(t0 + 110);
    chk("t1_sync_fall", sync_fall_cyc - t0, 1);
    chk("t1_first_fall", first_fall_cyc - t0, 3);
    chk("t1_last_fall", last_fall_cyc - t0, 95);
    chk("t1_sync_rise", sync_rise_cyc - t0, 99);
    chk("t1_done_cyc", done_cyc - t0, 103);
    chk("t1_n_done", n_done, 1);
    chk("t1_busy_cycles", n_busy - busy0, 102);
    chk("t1_bits", last_frame_bits, 24);
    chk("t1_frame", last_frame, 24'h00A5C3);
    chk("t1_lv_at_done", lv_at_done, 16'hA5C3);
    chk("t1_din_stable", din_viol, 0);

    // Three requests while busy: last write wins, follow-on frame starts right after done
    t0 = cyc; frames0 = n_frames; acks0 = n_ack;
    a_wr_req = 1'b1; a_wr_data = 16'h1000; a_wr_pd = 2'b01;
    @(negedge clk); a_wr_req = 1'b0;
    wait_until(t0 + 10); a_wr_req = 1'b1; a_wr_data = 16'h1111; a_wr_pd = 2'b00;
    @(negedge clk); a_wr_req = 1'b0;
    wait_until(t0 + 20); a_wr_req = 1'b1; a_wr_data = 16'h2222;
    @(negedge clk); a_wr_req = 1'b0;
    wait_until(t0 + 30); a_wr_req = 1'b1; a_wr_data = 16'h3333;
    @(negedge clk); a_wr_req = 1'b0;
    wait_until(t0 + 110);
    chk("t2_first_frame", last_frame, 24'h011000);
    chk("t2_first_done", done_cyc - t0, 103);
    chk("t2_next_sync_fall", sync_fall_cyc - t0, 104);
    wait_until(t0 + 215);
    chk("t2_acks", n_ack - acks0, 4);
    chk("t2_frames", n_frames - frames0, 2);
    chk("t2_second_frame", last_frame, 24'h003333);
    chk("t2_second_done", done_cyc - t0, 206);
    chk("t2_last_value", a_last_value, 16'h3333);

    // Reset at cycle 40 of a frame with a request parked
    t0 = cyc; frames0 = n_frames; done0 = n_done;
    a_wr_req = 1'b1; a_wr_data = 16'hBEEF; a_wr_pd = 2'b00;
    @(negedge clk); a_wr_req = 1'b0;
    wait_until(t0 + 20); a_wr_req = 1'b1; a_wr_data = 16'hCCCC;
    @(negedge clk); a_wr_req = 1'b0;
    wait_until(t0 + 40);
    chk("t5_sclk_low_before_rst", a_sclk, 0);
    #1 rstn = 1'b0;
    #1;
    chk("t5_rst_sync_n", a_sync_n, 1);
    chk("t5_rst_sclk", a_sclk, 1);
    chk("t5_rst_din", a_din, 0);
    chk("t5_rst_busy", a_busy, 0);
    chk("t5_rst_last_value", a_last_value, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_no_done", n_done - done0, 0);
    chk("t5_no_frame", n_frames - frames0, 0);
    chk("t5_idle_sync", a_sync_n, 1);
    t0 = cyc;
    a_wr_req = 1'b1; a_wr_data = 16'h0001;
    @(negedge clk); a_wr_req = 1'b0;
    wait_until(t0 + 110);
    chk("t5_frame", last_frame, 24'h000001);
    chk("t5_bits", last_frame_bits, 24);
    chk("t5_done_cyc", done_cyc - t0, 103);
    chk("t5_last_value", a_last_value, 16'h0001);

    // force_zero edge mid-frame while 0x4444 is parked
    t0 = cyc; frames0 = n_frames;
    a_wr_req = 1'b1; a_wr_data = 16'h7777; a_wr_pd = 2'b10;
    @(negedge clk); a_wr_req = 1'b0;
    wait_until(t0 + 20); a_wr_req = 1'b1; a_wr_data = 16'h4444; a_wr_pd = 2'b00;
    @(negedge clk); a_wr_req = 1'b0;
    wait_until(t0 + 40); a_force_zero = 1'b1;
    wait_until(t0 + 110);
    chk("t3_first_frame", last_frame, 24'h027777);
    chk("t3_first_lv", a_last_value, 16'h7777);
    chk("t3_zero_sync_fall", sync_fall_cyc - t0, 104);
    wait_until(t0 + 215);
    chk("t3_zero_frame", last_frame, 24'h000000);
    chk("t3_zero_done", done_cyc - t0, 206);
    chk("t3_frames", n_frames - frames0, 2);
    chk("t3_last_value", a_last_value, 16'h0000);

    // force_zero edge and wr_req in the same idle cycle
    a_force_zero = 1'b0;
    repeat (2) @(negedge clk);
    t0 = cyc; frames0 = n_frames; acks0 = n_ack;
    a_force_zero = 1'b1; a_wr_req = 1'b1; a_wr_data = 16'h5555; a_wr_pd = 2'b01;
    @(negedge clk); a_wr_req = 1'b0;
    chk("t4_no_ack_c1", a_wr_ack, 0);
    chk("t4_sync_c1", a_sync_n, 0);
    wait_until(t0 + 150);
    chk("t4_frame", last_frame, 24'h000000);
    chk("t4_done_cyc", done_cyc - t0, 103);
    chk("t4_frames", n_frames - frames0, 1);
    chk("t4_acks", n_ack - acks0, 0);
    chk("t4_last_value", a_last_value, 16'h0000);
    a_force_zero = 1'b0;

    // Minimum parameters on instance B
    @(negedge clk);
    b_wr_req = 1'b1; b_wr_data = 16'h9C3A; b_wr_pd = 2'b11;
    @(negedge clk);
    b_wr_req = 1'b0;
    chk("t6_ack_c1", b_wr_ack, 1);
    rxb = 24'h0; nb = 0; ffb = 0; dkb = 0; spb = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      if (spb && !b_sclk && !b_sync_n) begin
        rxb = {rxb[22:0], b_din};
        nb++;
        if (nb == 1) ffb = k;
      end
      if (b_done && dkb == 0) dkb = k;
      spb = b_sclk;
      @(negedge clk);
    end
    chk("t6_bits", nb, 24);
    chk("t6_frame", rxb, 24'h039C3A);
    chk("t6_first_fall", ffb, 2);
    chk("t6_done_cyc", dkb, 51);
    chk("t6_last_value", b_last_value, 16'h9C3A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
